filter_ewma_mc: RTL and testbench

//  Multi-channel exponentially-weighted moving-average filter; successor to the single-channel EWMA.

---
 rtl/filter_ewma_mc.sv | 122 ++++++++++++
 tb/tb_filter_ewma_mc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_ewma_mc.sv
// Multi-channel EWMA filter: CHANNELS streams share one 2-stage pipeline.
// Per-channel state and seed flags live in register arrays.
module filter_ewma_mc #(
    parameter int DATA_BITS  = 12,
    parameter int ALPHA_BITS = 8,
    parameter int CHANNELS   = 4,
    parameter int CH_BITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_BITS-1:0]    in_ch,
    input  logic [DATA_BITS-1:0]  din,
    input  logic [ALPHA_BITS:0]   alpha,
    input  logic                  bypass,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_BITS-1:0]    out_ch,
    output logic [DATA_BITS-1:0]  dout
);
    localparam int SUM_W = DATA_BITS + ALPHA_BITS + 1;
    localparam int NSLOT = 1 << CH_BITS;
    localparam logic [ALPHA_BITS:0] FULL = {1'b1, {ALPHA_BITS{1'b0}}};
    localparam logic [SUM_W-1:0] ROUND = SUM_W'(1) << (ALPHA_BITS - 1);

    logic                  stall;
    logic                  accept;
    logic                  ch_ok;
    logic                  fwd;
    logic [ALPHA_BITS:0]   a_clamp;
    logic [DATA_BITS-1:0]  prev;
    logic [DATA_BITS-1:0]  y;
    logic [SUM_W-1:0]      p1_n;
    logic [SUM_W-1:0]      p2_n;
    logic [SUM_W-1:0]      sum;
    logic                  unused_sum;

    logic                  v1;
    logic [CH_BITS-1:0]    ch1;
    logic [DATA_BITS-1:0]  din1;
    logic                  byp1;
    logic [SUM_W-1:0]      p1_q;
    logic [SUM_W-1:0]      p2_q;

    logic [DATA_BITS-1:0]  state [NSLOT];
    logic [NSLOT-1:0]      seeded;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign ch_ok    = int'(in_ch) < CHANNELS;

    // Weight clamp, state forwarding from stage 1, and the two products.
    always_comb begin
        a_clamp = (alpha > FULL) ? FULL : alpha;
        fwd     = v1 & (ch1 == in_ch);
        prev    = fwd ? y : state[in_ch];
        p1_n    = SUM_W'(a_clamp) * SUM_W'(din);
        p2_n    = SUM_W'(FULL - a_clamp) * SUM_W'(prev);
    end

    // Rounded blend, or the raw sample when bypassing or seeding.
    always_comb begin
        sum = p1_q + p2_q + ROUND;
        if (byp1 | ~seeded[ch1])
            y = din1;
        else
            y = sum[ALPHA_BITS +: DATA_BITS];
    end

    assign unused_sum = ^{sum[SUM_W-1], sum[ALPHA_BITS-1:0]};

    // Stage 1: capture the accepted sample and its products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            ch1  <= '0;
            din1 <= '0;
            byp1 <= 1'b0;
            p1_q <= '0;
            p2_q <= '0;
        end else if (clear) begin
            v1 <= 1'b0;
        end else if (!stall) begin
            v1 <= accept & ch_ok;
            if (accept) begin
                ch1  <= in_ch;
                din1 <= din;
                byp1 <= bypass;
                p1_q <= p1_n;
                p2_q <= p2_n;
            end
        end
    end

    // Stage 2: output register plus per-channel state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            dout      <= '0;
            seeded    <= '0;
            for (int i = 0; i < NSLOT; i++) state[i] <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            seeded    <= '0;
            for (int i = 0; i < NSLOT; i++) state[i] <= '0;
        end else if (!stall) begin
            if (v1) begin
                out_valid   <= 1'b1;
                out_ch      <= ch1;
                dout        <= y;
                state[ch1]  <= y;
                seeded[ch1] <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_filter_ewma_mc.sv
// Bench for filter_ewma_mc: directed steps plus random traffic
// against a per-channel arithmetic reference model.
module tb_filter_ewma_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic [11:0] din;
    logic [8:0]  alpha;
    logic        bypass;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [11:0] dout;

    int n_checks = 0;
    int n_pass   = 0;
    int st[4];
    bit sd[4];
    logic [13:0] q[$];
    int last_d = -1;

    filter_ewma_mc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .din(din), .alpha(alpha),
        .bypass(bypass), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_flush();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            st[i] = 0;
            sd[i] = 0;
        end
    endtask

    task automatic model_accept(input int ch, input int d, input int a,
                                input bit b);
        int aa;
        int y;
        logic [11:0] y12;
        logic [1:0]  c2;
        aa = (a > 256) ? 256 : a;
        if (b || !sd[ch]) y = d;
        else y = (aa * d + (256 - aa) * st[ch] + 128) / 256;
        st[ch] = y;
        sd[ch] = 1;
        y12 = y[11:0];
        c2 = ch[1:0];
        q.push_back({c2, y12});
    endtask

    // Called at a falling edge; drives one cycle and scores it.
    task automatic step(input bit v, input int ch, input int d,
                        input int a, input bit b, input bit r,
                        input bit c);
        logic [13:0] e;
        in_valid  = v;
        in_ch     = ch[1:0];
        din       = d[11:0];
        alpha     = a[8:0];
        bypass    = b;
        out_ready = r;
        clear     = c;
        #1;
        if (out_valid && out_ready && !c) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_ch", 32'(out_ch), 32'(e[13:12]));
                check("dout", 32'(dout), 32'(e[11:0]));
                last_d = int'(dout);
            end
        end
        if (c) model_flush();
        else if (v && in_ready) model_accept(ch, d, a, b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        idle(2);
        check("drain_empty", 32'(q.size()), 0);
    endtask

    logic [11:0] held_d;
    logic [1:0]  held_c;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_ch = 0; din = 0; alpha = 0;
        bypass = 0; clear = 0; out_ready = 1;
        model_flush();
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_out_ch", 32'(out_ch), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // seed then halve twice
        step(1, 0, 1000, 128, 0, 1, 0);
        step(1, 0, 0, 128, 0, 1, 0);
        step(1, 0, 0, 128, 0, 1, 0);
        drain();
        check("t1_final", 32'(last_d), 250);

        // back-to-back same channel via forwarding
        step(1, 1, 4095, 64, 0, 1, 0);
        step(1, 1, 0, 64, 0, 1, 0);
        step(1, 1, 0, 64, 0, 1, 0);
        drain();
        check("t2_final", 32'(last_d), 2303);

        // round-robin interleave
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++)
                step(1, c, 100 * (c + 1), 100, 0, 1, 0);
        drain();

        // alpha full scale, alpha zero, bypass
        step(1, 3, 3210, 256, 0, 1, 0);
        drain();
        check("alpha_full", 32'(last_d), 3210);
        step(1, 3, 4000, 0, 0, 1, 0);
        drain();
        check("alpha_zero", 32'(last_d), 3210);
        step(1, 3, 7, 50, 1, 1, 0);
        drain();
        check("bypass", 32'(last_d), 7);
        step(1, 3, 0, 128, 0, 1, 0);
        drain();
        check("bypass_state", 32'(last_d), 4);

        // back-pressure hold
        step(1, 2, 1234, 200, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        held_d = dout;
        held_c = out_ch;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 999, 128, 0, 0, 0);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_dout", 32'(dout), 32'(held_d));
            check("stall_out_ch", 32'(out_ch), 32'(held_c));
        end
        drain();

        // clear mid-stream, then reseed ch2
        step(1, 2, 3000, 128, 0, 1, 0);
        step(1, 0, 3000, 128, 0, 0, 1);
        check("clear_out_valid", 32'(out_valid), 0);
        idle(3);
        check("clear_flushed", 32'(q.size()), 0);
        step(1, 2, 555, 10, 0, 1, 0);
        drain();
        check("clear_seed", 32'(last_d), 555);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(3, 0),
                 $urandom_range(4095, 0), $urandom_range(300, 0),
                 $urandom_range(7, 0) == 0, $urandom_range(3, 0) != 0,
                 $urandom_range(60, 0) == 0);
        end
        drain();

        // async reset while stalled
        step(1, 1, 800, 128, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_dout", 32'(dout), 0);
        check("mid_rst_ch", 32'(out_ch), 0);
        model_flush();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 321, 128, 0, 1, 0);
        drain();
        check("post_rst_seed", 32'(last_d), 321);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
